// File: rtl/snn_pkg.sv
// Shared sizes and FSM encoding for the spike accumulator.
package snn_pkg;
  localparam int N_NEURON = 4;
  localparam int WEIGHT_W = 8;
  localparam int POT_W    = 16;
  localparam int ADDR_W   = 8;
  localparam int WORD_W   = N_NEURON * WEIGHT_W;

  typedef enum logic [1:0] {IDLE, READ, ACC, FIRE} state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_ACC  = ACC;
  localparam logic [1:0] ST_FIRE = FIRE;
endpackage

// File: rtl/spike_accumulator_if.sv
// Event / step / weight-write / SRAM / status bundle for the spike accumulator.
interface spike_accumulator_if;
  import snn_pkg::*;

  logic                         ev_valid;
  logic                         ev_ready;
  logic [ADDR_W-1:0]            ev_idx;
  logic                         step;
  logic                         wr_en;
  logic                         wr_ready;
  logic [ADDR_W-1:0]            wr_addr;
  logic [WORD_W-1:0]            wr_data;
  logic                         sram_cs;
  logic                         sram_oe;
  logic                         sram_web;
  logic [ADDR_W-1:0]            sram_a;
  logic [WORD_W-1:0]            sram_di;
  logic [WORD_W-1:0]            sram_do;
  logic [N_NEURON-1:0]          spike;
  logic                         spike_valid;
  logic [N_NEURON*POT_W-1:0]    pot;
  logic                         busy;

  modport master (
    output ev_valid, ev_idx, step, wr_en, wr_addr, wr_data, sram_do,
    input  ev_ready, wr_ready, sram_cs, sram_oe, sram_web, sram_a, sram_di,
           spike, spike_valid, pot, busy
  );

  modport slave (
    input  ev_valid, ev_idx, step, wr_en, wr_addr, wr_data, sram_do,
    output ev_ready, wr_ready, sram_cs, sram_oe, sram_web, sram_a, sram_di,
           spike, spike_valid, pot, busy
  );
endinterface

// File: rtl/lif_lane.sv
// One leaky integrate-and-fire neuron: saturating weight accumulate, or
// threshold fire / leak toward zero. Purely combinational next-potential.
module lif_lane
  import snn_pkg::*;
#(
  parameter logic signed [POT_W-1:0] THRESH = 16'sd100,
  parameter logic        [POT_W-1:0] LEAK   = 16'd1
) (
  input  logic                       acc_en,
  input  logic                       fire_en,
  input  logic signed [WEIGHT_W-1:0] weight,
  input  logic signed [POT_W-1:0]    pot_q,
  output logic signed [POT_W-1:0]    pot_d,
  output logic                       fire
);
  localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
  localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

  logic signed [POT_W:0] pot_x, leak_x, sum;

  always_comb begin
    pot_x  = {pot_q[POT_W-1], pot_q};
    leak_x = {1'b0, LEAK};
    sum    = pot_x + {{(POT_W+1-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
    pot_d  = pot_q;
    fire   = 1'b0;
    if (acc_en) begin
      // top two sum bits disagree only when the 16-bit result overflowed
      if (sum[POT_W] != sum[POT_W-1]) pot_d = sum[POT_W] ? POT_MIN : POT_MAX;
      else                            pot_d = sum[POT_W-1:0];
    end else if (fire_en) begin
      if (pot_q >= THRESH) begin
        fire  = 1'b1;
        pot_d = '0;
      end else if (pot_x > leak_x) begin
        pot_d = pot_q - LEAK;
      end else if (pot_x < -leak_x) begin
        pot_d = pot_q + LEAK;
      end else begin
        pot_d = '0;
      end
    end
  end
endmodule

// File: rtl/spike_accumulator.sv
// Event-driven SNN core: each input event reads one weight word from SRAM and
// accumulates it into N_NEURON potentials; a step pulse fires and leaks.
module spike_accumulator
  import snn_pkg::*;
#(
  parameter logic signed [POT_W-1:0] THRESH = 16'sd100,
  parameter logic        [POT_W-1:0] LEAK   = 16'd1
) (
  input  logic                clk,
  input  logic                rst,
  spike_accumulator_if.slave  bus
);
  logic [1:0]                     state_q, state_d;
  logic [ADDR_W-1:0]              idx_q, idx_d;
  logic                           step_pend_q, step_pend_d;
  logic [N_NEURON-1:0][POT_W-1:0] pot_q, pot_d;
  logic [N_NEURON-1:0]            spike_q, spike_d;
  logic                           spike_valid_q, spike_valid_d;
  logic [N_NEURON-1:0]            lane_fire;

  logic step_any, ev_ready, ev_fire, wr_ready, wr_fire, acc_en, fire_en;

  always_comb begin
    step_any = bus.step | step_pend_q;
    ev_ready = !rst && (state_q == ST_IDLE) && !step_any;
    ev_fire  = ev_ready && bus.ev_valid;
    wr_ready = ev_ready && !bus.ev_valid;
    wr_fire  = wr_ready && bus.wr_en;

    state_d       = state_q;
    idx_d         = idx_q;
    step_pend_d   = step_pend_q;
    spike_d       = spike_q;
    spike_valid_d = 1'b0;
    acc_en        = 1'b0;
    fire_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step_any) begin
          state_d = ST_FIRE;
        end else if (ev_fire) begin
          idx_d   = bus.ev_idx;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_ACC;
        if (bus.step) step_pend_d = 1'b1;
      end
      ST_ACC: begin
        acc_en  = 1'b1;
        state_d = ST_IDLE;
        if (bus.step) step_pend_d = 1'b1;
      end
      ST_FIRE: begin
        fire_en       = 1'b1;
        spike_d       = lane_fire;
        spike_valid_d = 1'b1;
        // a step landing in FIRE itself schedules one more timestep
        step_pend_d   = bus.step;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar k = 0; k < N_NEURON; k++) begin : g_lane
    lif_lane #(.THRESH(THRESH), .LEAK(LEAK)) u_lane (
      .acc_en  (acc_en),
      .fire_en (fire_en),
      .weight  (bus.sram_do[k*WEIGHT_W +: WEIGHT_W]),
      .pot_q   (pot_q[k]),
      .pot_d   (pot_d[k]),
      .fire    (lane_fire[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      step_pend_q   <= 1'b0;
      pot_q         <= '0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      step_pend_q   <= step_pend_d;
      pot_q         <= pot_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
    end
  end

  logic              sram_cs, sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [WORD_W-1:0] sram_di;

  always_comb begin
    sram_cs  = 1'b0;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_di  = '0;
    if (!rst && state_q == ST_READ) begin
      sram_cs = 1'b1;
      sram_a  = idx_q;
    end else if (wr_fire) begin
      sram_cs  = 1'b1;
      sram_web = 1'b0;
      sram_a   = bus.wr_addr;
      sram_di  = bus.wr_data;
    end
  end

  assign bus.ev_ready    = ev_ready;
  assign bus.wr_ready    = wr_ready;
  assign bus.sram_cs     = sram_cs;
  assign bus.sram_oe     = 1'b1;
  assign bus.sram_web    = sram_web;
  assign bus.sram_a      = sram_a;
  assign bus.sram_di     = sram_di;
  assign bus.spike       = spike_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.pot         = pot_q;
  assign bus.busy        = (state_q != ST_IDLE);
endmodule
